xadc_drp_responder: RTL

- Synthesizable responder for the 7-series XADC Dynamic Reconfiguration Port (DRP), acting as the primitive end of the DRP protocol.
- Serves the DRP initiator in the xadc_7000 controller so the register path can be exercised in simulation and on boards without the XADC hard block.
- Contains a 128x16 DRP register space, a channel-sequenced conversion engine driven by digital measurement inputs, min/max trackers, and eoc/eos/busy status outputs.

---
 rtl/xadc_drp_responder_if.sv | 15 +
 rtl/xadc_drp_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_responder_if.sv
// DRP bus between an initiator (master) and the responder (slave).
// One request strobe per transaction; drdy closes it.
interface xadc_drp_responder_if;
   logic        den;
   logic        dwe;
   logic [6:0]  daddr;
   logic [15:0] di;
   logic [15:0] do_o;
   logic        drdy;

   modport master (output den, output dwe, output daddr, output di,
                   input do_o, input drdy);
   modport slave  (input den, input dwe, input daddr, input di,
                   output do_o, output drdy);
endinterface

// File: rtl/xadc_drp_responder.sv
// Behavioural stand-in for the 7-series XADC DRP endpoint: register file,
// round-robin conversion sequencer over measurement inputs, min/max tracking.
module xadc_drp_responder #(
   parameter int NCH         = 4,
   parameter int CONV_CYCLES = 26,
   parameter int RD_LAT      = 2,
   parameter int WR_LAT      = 1
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   xadc_drp_responder_if.slave  drp,
   input  logic [12*NCH-1:0]    meas,
   output logic [4:0]           channel,
   output logic                 eoc,
   output logic                 eos,
   output logic                 busy,
   output logic                 req_err
);

   localparam int CW = $clog2(CONV_CYCLES + 1);
   localparam int LW = 8;
   localparam logic [6:0] MASK_ADDR = 7'h48;

   typedef enum logic {IDLE, CONV} seq_state_t;

   logic [15:0]   cfg [64];
   logic [15:0]   res [16];
   logic [15:0]   max0, max1, min0, min1;

   logic [LW-1:0] rem;
   logic          t_wr;
   logic [6:0]    t_addr;
   logic [15:0]   t_di, t_rdata;
   logic [15:0]   do_q;
   logic          drdy_q;

   seq_state_t    state;
   logic [CW-1:0] cnt;
   logic [4:0]    cur;

   logic          pending, accept, imm, fire, f_wr, wr_commit, mask_wr;
   logic [LW-1:0] acc_lat;
   logic [6:0]    f_addr;
   logic [15:0]   f_di, f_rdata, rd_now, v_now;
   logic [11:0]   cur_code;
   logic [NCH-1:0] mask, new_mask;

   function automatic logic [4:0] lowest(input logic [NCH-1:0] m);
      logic [4:0] r;
      r = '0;
      for (int k = NCH - 1; k >= 0; k--) if (m[k]) r = 5'(k);
      return r;
   endfunction

   function automatic logic [4:0] highest(input logic [NCH-1:0] m);
      logic [4:0] r;
      r = '0;
      for (int k = 0; k < NCH; k++) if (m[k]) r = 5'(k);
      return r;
   endfunction

   // Smallest enabled channel above c, wrapping to the lowest enabled one.
   function automatic logic [4:0] next_ch(input logic [NCH-1:0] m, input logic [4:0] c);
      logic [4:0] r;
      r = lowest(m);
      for (int k = NCH - 1; k >= 0; k--) if (m[k] && 5'(k) > c) r = 5'(k);
      return r;
   endfunction

   always_comb begin
      rd_now = 16'h0000;
      if (drp.daddr[6])               rd_now = cfg[drp.daddr[5:0]];
      else if (drp.daddr == 7'h20)    rd_now = max0;
      else if (drp.daddr == 7'h21)    rd_now = max1;
      else if (drp.daddr == 7'h24)    rd_now = min0;
      else if (drp.daddr == 7'h25)    rd_now = min1;
      else if (drp.daddr < 7'(NCH))   rd_now = res[drp.daddr[3:0]];
   end

   // A transaction stays pending until the cycle after its drdy.
   assign pending   = (rem != '0) | drdy_q;
   assign accept    = drp.den & ~pending;
   assign acc_lat   = drp.dwe ? LW'(WR_LAT) : LW'(RD_LAT);
   assign imm       = accept & (acc_lat == LW'(1));
   assign fire      = imm | (rem == LW'(1));
   assign f_wr      = imm ? drp.dwe   : t_wr;
   assign f_addr    = imm ? drp.daddr : t_addr;
   assign f_di      = imm ? drp.di    : t_di;
   assign f_rdata   = imm ? rd_now    : t_rdata;
   assign wr_commit = fire & f_wr & f_addr[6];
   assign mask_wr   = wr_commit & (f_addr == MASK_ADDR);
   assign new_mask  = f_di[NCH-1:0];
   assign mask      = cfg[8][NCH-1:0];

   always_comb begin
      cur_code = '0;
      for (int k = 0; k < NCH; k++) if (cur == 5'(k)) cur_code = meas[12*k +: 12];
   end
   assign v_now = {cur_code, 4'b0000};

   assign drp.do_o = do_q;
   assign drp.drdy = drdy_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rem     <= '0;
         drdy_q  <= 1'b0;
         do_q    <= '0;
         t_wr    <= 1'b0;
         t_addr  <= '0;
         t_di    <= '0;
         t_rdata <= '0;
         req_err <= 1'b0;
         for (int i = 0; i < 64; i++) cfg[i] <= '0;
      end else begin
         drdy_q <= fire;
         if (fire && !f_wr) do_q <= f_rdata;
         if (wr_commit) cfg[f_addr[5:0]] <= f_di;
         if (drp.den && pending) req_err <= 1'b1;
         if (rem != '0)          rem <= rem - LW'(1);
         else if (accept && !imm) rem <= acc_lat - LW'(1);
         if (accept) begin
            t_wr    <= drp.dwe;
            t_addr  <= drp.daddr;
            t_di    <= drp.di;
            t_rdata <= rd_now;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= IDLE;
         cnt     <= '0;
         cur     <= '0;
         channel <= '0;
         eoc     <= 1'b0;
         eos     <= 1'b0;
         busy    <= 1'b0;
         max0    <= 16'h0000;
         max1    <= 16'h0000;
         min0    <= 16'hFFFF;
         min1    <= 16'hFFFF;
         for (int i = 0; i < 16; i++) res[i] <= '0;
      end else begin
         eoc <= 1'b0;
         eos <= 1'b0;
         // A mask write restarts the sequence and wins over a coincident completion.
         if (mask_wr) begin
            if (new_mask != '0) begin
               state <= CONV;
               cnt   <= CW'(CONV_CYCLES - 1);
               cur   <= lowest(new_mask);
               busy  <= 1'b1;
            end else begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: if (mask != '0) begin
                  state <= CONV;
                  cnt   <= CW'(CONV_CYCLES - 1);
                  cur   <= lowest(mask);
                  busy  <= 1'b1;
               end
               CONV: if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  res[cur[3:0]] <= v_now;
                  channel       <= cur;
                  eoc           <= 1'b1;
                  eos           <= (cur == highest(mask));
                  if (cur == 5'd0) begin
                     if (v_now > max0) max0 <= v_now;
                     if (v_now < min0) min0 <= v_now;
                  end
                  if (cur == 5'd1) begin
                     if (v_now > max1) max1 <= v_now;
                     if (v_now < min1) min1 <= v_now;
                  end
                  if (mask == '0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     cur <= next_ch(mask, cur);
                     cnt <= CW'(CONV_CYCLES - 1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
